gfmac_arbiter: RTL and testbench

//  Shares one GF(2^5) multiply-accumulate datapath (lcpmult + gfadder + 5-bit acc register) among NREQ requesters
//  (syndrome, key-equation, Chien, Forney stages). Round-robin arbitration with optional locked bursts for

---
 rtl/gfmac_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_gfmac_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gfmac_arbiter.sv
// gfmac_arbiter: one GF(2^5) multiply-accumulate datapath shared by NREQ
// requesters. Round-robin arbitration with optional locked bursts, capped at
// HOLD_MAX consecutive locked grants while someone else is waiting.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no owner; grant goes to first requester from ptr with wrap
// ST_OWN   | owner_q holds a locked burst; burst_cnt_q counts its beats
module gfmac_arbiter #(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   lock,
  input  logic [NREQ-1:0]   acc_clr,
  input  logic [5*NREQ-1:0] op_a,
  input  logic [5*NREQ-1:0] op_b,
  output logic [NREQ-1:0]   gnt,
  output logic [4:0]        result,
  output logic              result_vld,
  output logic [2:0]        result_id
);

  typedef enum logic {ST_IDLE, ST_OWN} state_e;

  localparam logic [4:0] HOLD_CNT = 5'(HOLD_MAX);
  localparam logic [3:0] NREQ4    = 4'(NREQ);

  state_e     state_q, state_d;
  logic [2:0] owner_q, owner_d;
  logic [2:0] ptr_q, ptr_d;
  logic [4:0] burst_cnt_q, burst_cnt_d;
  logic [4:0] acc_q;
  logic [4:0] result_q;
  logic       result_vld_q;
  logic [2:0] result_id_q;

  // Requester vectors padded to the 8-entry maximum so every index is 3 bits.
  logic [7:0] req8, lock8, clr8, mask8, gnt8;
  logic [4:0] a_arr [8];
  logic [4:0] b_arr [8];

  logic       others_waiting;
  logic       rr_found;
  logic [2:0] rr_idx;
  logic [3:0] rr_pos;
  logic [3:0] ptr_next;
  logic       rr_en;
  logic       gnt_vld;
  logic [2:0] gidx;
  logic       first_beat;
  logic [4:0] prod;
  logic [4:0] acc_next;

  // GF(2^5) multiply, x^5 = x^2 + 1: shift-and-add with reduction per step.
  function automatic logic [4:0] gf_mul(input logic [4:0] a, input logic [4:0] b);
    logic [4:0] r;
    logic [4:0] aa;
    r  = '0;
    aa = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) r = r ^ aa;
      aa = aa[4] ? ({aa[3:0], 1'b0} ^ 5'b00101) : {aa[3:0], 1'b0};
    end
    return r;
  endfunction

  assign req8  = 8'(req);
  assign lock8 = 8'(lock);
  assign clr8  = 8'(acc_clr);

  // Unpack operand buses into per-requester arrays; unused slots read zero.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    for (int i = 0; i < NREQ; i++) begin
      a_arr[i] = op_a[5*i +: 5];
      b_arr[i] = op_b[5*i +: 5];
    end
  end

  // Candidate set for round robin: a forced rotate hides the current owner.
  always_comb begin
    others_waiting = |(req8 & ~(8'd1 << owner_q));
    mask8          = req8;
    if (state_q == ST_OWN && req8[owner_q] && burst_cnt_q == HOLD_CNT) begin
      mask8 = req8 & ~(8'd1 << owner_q);
    end
  end

  // Round-robin search starting at ptr_q, wrapping at NREQ.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = '0;
    for (int off = 0; off < NREQ; off++) begin
      rr_pos = {1'b0, ptr_q} + 4'(off);
      if (rr_pos >= NREQ4) rr_pos = rr_pos - NREQ4;
      if (!rr_found && mask8[rr_pos[2:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_pos[2:0];
      end
    end
    ptr_next = {1'b0, rr_idx} + 4'd1;
    if (ptr_next == NREQ4) ptr_next = '0;
  end

  // Next-state and grant selection.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    ptr_d       = ptr_q;
    gnt_vld     = 1'b0;
    gidx        = '0;
    first_beat  = 1'b1;
    rr_en       = 1'b1;

    // Owner continues unless it dropped req or must yield after HOLD_MAX beats.
    if (state_q == ST_OWN && req8[owner_q] &&
        !(burst_cnt_q == HOLD_CNT && others_waiting)) begin
      rr_en      = 1'b0;
      gnt_vld    = 1'b1;
      gidx       = owner_q;
      first_beat = 1'b0;
      if (burst_cnt_q != HOLD_CNT) burst_cnt_d = burst_cnt_q + 5'd1;
      if (!lock8[owner_q]) begin
        state_d     = ST_IDLE;
        burst_cnt_d = '0;
      end
    end

    if (rr_en) begin
      state_d     = ST_IDLE;
      burst_cnt_d = '0;
      if (rr_found) begin
        gnt_vld = 1'b1;
        gidx    = rr_idx;
        ptr_d   = ptr_next[2:0];
        if (lock8[rr_idx]) begin
          state_d     = ST_OWN;
          owner_d     = rr_idx;
          burst_cnt_d = 5'd1;
        end
      end
    end
  end

  // Datapath: any new ownership starts a fresh sum, as does an explicit clear.
  always_comb begin
    prod     = gf_mul(a_arr[gidx], b_arr[gidx]);
    acc_next = (clr8[gidx] || first_beat) ? prod : (acc_q ^ prod);
    gnt8     = (gnt_vld && reset_n) ? (8'd1 << gidx) : 8'd0;
  end

  assign gnt        = gnt8[NREQ-1:0];
  assign result     = result_q;
  assign result_vld = result_vld_q;
  assign result_id  = result_id_q;

  // Arbiter state and result registers; reset drops any burst in flight.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      ptr_q        <= '0;
      burst_cnt_q  <= '0;
      acc_q        <= '0;
      result_q     <= '0;
      result_vld_q <= 1'b0;
      result_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      burst_cnt_q <= burst_cnt_d;
      if (gnt_vld) begin
        acc_q        <= acc_next;
        result_q     <= acc_next;
        result_id_q  <= gidx;
        result_vld_q <= 1'b1;
      end else begin
        result_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gfmac_arbiter.sv
// Directed bench for gfmac_arbiter (NREQ=4, HOLD_MAX=8).
module tb_gfmac_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  req, lock, acc_clr;
  logic [19:0] op_a, op_b;
  logic [3:0]  gnt;
  logic [4:0]  result;
  logic        result_vld;
  logic [2:0]  result_id;

  int checks = 0;
  int errors = 0;

  gfmac_arbiter #(.NREQ(4), .HOLD_MAX(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .lock       (lock),
    .acc_clr    (acc_clr),
    .op_a       (op_a),
    .op_b       (op_b),
    .gnt        (gnt),
    .result     (result),
    .result_vld (result_vld),
    .result_id  (result_id)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic apply_reset;
    reset_n = 1'b0;
    req = '0; lock = '0; acc_clr = '0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    req = 4'b1111; lock = '0; acc_clr = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++; if (result !== 5'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
    checks++; if (result_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", result_vld); end
    checks++; if (result_id !== 3'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", result_id); end
    reset_n = 1'b1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b expected 0001", gnt); end
    @(posedge clock); #1;
    checks++; if (result_vld !== 1'b1 || result_id !== 3'd0) begin errors++; $display("FAIL reset_first_result: got vld %b id %0d expected vld 1 id 0", result_vld, result_id); end
    req = '0;
  endtask

  task automatic test_single_op;
    apply_reset();
    req = 4'b0001; op_a[4:0] = 5'd2; op_b[4:0] = 5'd16;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b expected 0001", gnt); end
    @(posedge clock); #1;
    checks++; if (result !== 5'd5) begin errors++; $display("FAIL single_result: got %0d expected 5", result); end
    checks++; if (result_id !== 3'd0 || result_vld !== 1'b1) begin errors++; $display("FAIL single_tag: got id %0d vld %b expected id 0 vld 1", result_id, result_vld); end
    req = '0;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_idle_gnt: got %b expected 0000", gnt); end
    @(posedge clock); #1;
    checks++; if (result_vld !== 1'b0 || result !== 5'd5) begin errors++; $display("FAIL single_idle: got vld %b result %0d expected vld 0 result 5", result_vld, result); end
  endtask

  task automatic test_burst_mac;
    apply_reset();
    req = 4'b0001; lock = 4'b0001; acc_clr = 4'b0001;
    op_a[4:0] = 5'd2; op_b[4:0] = 5'd16;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL burst_gnt1: got %b expected 0001", gnt); end
    @(posedge clock); #1;
    checks++; if (result !== 5'd5) begin errors++; $display("FAIL burst_beat1: got %0d expected 5", result); end
    lock = 4'b0000; acc_clr = 4'b0000;
    op_a[4:0] = 5'd3; op_b[4:0] = 5'd1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL burst_gnt2: got %b expected 0001", gnt); end
    @(posedge clock); #1;
    checks++; if (result !== 5'd6) begin errors++; $display("FAIL burst_beat2: got %0d expected 6", result); end
    // burst ended: next grant starts a new sum even without acc_clr
    op_a[4:0] = 5'd1; op_b[4:0] = 5'd7;
    @(posedge clock); #1;
    checks++; if (result !== 5'd7) begin errors++; $display("FAIL burst_new_sum: got %0d expected 7", result); end
    req = '0;
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] exp_id[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [4:0] exp_r [5] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};
    apply_reset();
    op_a = {5'd4, 5'd3, 5'd2, 5'd1};
    op_b = {5'd1, 5'd1, 5'd1, 5'd1};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++; if (gnt !== exp_g[n]) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", n, gnt, exp_g[n]); end
      @(posedge clock); #1;
      checks++; if (result_id !== exp_id[n] || result !== exp_r[n]) begin errors++; $display("FAIL rr_result[%0d]: got id %0d result %0d expected id %0d result %0d", n, result_id, result, exp_id[n], exp_r[n]); end
    end
    req = '0;
  endtask

  task automatic test_starvation;
    apply_reset();
    lock = 4'b0001;
    op_a[4:0] = 5'd1; op_b[4:0] = 5'd1;
    op_a[14:10] = 5'd3; op_b[14:10] = 5'd1;
    for (int n = 1; n <= 8; n++) begin
      req = (n == 1) ? 4'b0001 : 4'b0101;
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL starve_hold[%0d]: got %b expected 0001", n, gnt); end
      @(posedge clock); #1;
      checks++; if (result !== (n[0] ? 5'd1 : 5'd0)) begin errors++; $display("FAIL starve_acc[%0d]: got %0d expected %0d", n, result, n[0]); end
    end
    #1;
    checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL starve_rotate: got %b expected 0100", gnt); end
    @(posedge clock); #1;
    checks++; if (result !== 5'd3 || result_id !== 3'd2) begin errors++; $display("FAIL starve_victor: got result %0d id %0d expected 3 id 2", result, result_id); end
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL starve_return: got %b expected 0001", gnt); end
    @(posedge clock); #1;
    checks++; if (result !== 5'd1 || result_id !== 3'd0) begin errors++; $display("FAIL starve_restart: got result %0d id %0d expected 1 id 0", result, result_id); end
    req = '0; lock = '0;
  endtask

  task automatic test_saturate;
    apply_reset();
    req = 4'b0001; lock = 4'b0001;
    op_a[4:0] = 5'd1; op_b[4:0] = 5'd1;
    for (int n = 1; n <= 12; n++) begin
      #1;
      checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL sat_gnt[%0d]: got %b expected 0001", n, gnt); end
      @(posedge clock); #1;
      checks++; if (result !== (n[0] ? 5'd1 : 5'd0)) begin errors++; $display("FAIL sat_acc[%0d]: got %0d expected %0d", n, result, n[0]); end
    end
    req = '0; lock = '0;
  endtask

  task automatic test_boundaries;
    logic [4:0] xv;
    apply_reset();
    req = 4'b0010;
    for (int x = 0; x < 32; x++) begin
      xv = 5'(x);
      op_a[9:5] = 5'd0; op_b[9:5] = xv;
      @(posedge clock); #1;
      checks++; if (result !== 5'd0) begin errors++; $display("FAIL zero_mul[%0d]: got %0d expected 0", x, result); end
      op_a[9:5] = 5'd1;
      @(posedge clock); #1;
      checks++; if (result !== xv) begin errors++; $display("FAIL one_mul[%0d]: got %0d expected %0d", x, result, xv); end
    end
    req = '0;
  endtask

  task automatic test_handover;
    apply_reset();
    req = 4'b0011; lock = 4'b0011;
    op_a[4:0] = 5'd2; op_b[4:0] = 5'd16;
    op_a[9:5] = 5'd1; op_b[9:5] = 5'd9;
    @(posedge clock); #1;
    checks++; if (result !== 5'd5 || result_id !== 3'd0) begin errors++; $display("FAIL ho_beat1: got %0d id %0d expected 5 id 0", result, result_id); end
    op_a[4:0] = 5'd3; op_b[4:0] = 5'd1;
    #1;
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ho_gnt2: got %b expected 0001", gnt); end
    @(posedge clock); #1;
    checks++; if (result !== 5'd6) begin errors++; $display("FAIL ho_beat2: got %0d expected 6", result); end
    req = 4'b0010; op_a[4:0] = 5'bx; op_b[4:0] = 5'bx;
    #1;
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ho_gnt3: got %b expected 0010", gnt); end
    @(posedge clock); #1;
    checks++; if (result !== 5'd9 || result_id !== 3'd1) begin errors++; $display("FAIL ho_new_owner: got %0d id %0d expected 9 id 1", result, result_id); end
    acc_clr = 4'b0010; op_b[9:5] = 5'd4;
    @(posedge clock); #1;
    checks++; if (result !== 5'd4) begin errors++; $display("FAIL ho_mid_clr: got %0d expected 4", result); end
    acc_clr = 4'b0000; op_b[9:5] = 5'd1;
    @(posedge clock); #1;
    checks++; if (result !== 5'd5) begin errors++; $display("FAIL ho_accum: got %0d expected 5", result); end
    req = '0; lock = '0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_burst_mac();
    test_round_robin();
    test_starvation();
    test_saturate();
    test_boundaries();
    test_handover();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
